// File: rtl/conv_weight_bank.sv
// Double-buffered conv weight store: serial valid/ready load into a shadow bank, parallel commit.
// Define WB_CHECKSUM_EN to add a running signed checksum of each committed weight set.
module conv_weight_bank #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned KERNEL_SIZE = 3,
   parameter int unsigned NUM_CH      = 4,
   localparam int unsigned TAPS_PER_CH = KERNEL_SIZE * KERNEL_SIZE,
   localparam int unsigned TAPS        = NUM_CH * TAPS_PER_CH,
   localparam int unsigned CNT_W       = $clog2(TAPS + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         valid_in,
   output logic                         ready_out,
   input  logic [DATA_WIDTH-1:0]        data_in,
   output logic                         loaded,
   input  logic                         start,
   output logic                         done,
   output logic [TAPS*DATA_WIDTH-1:0]   weights_out,
   output logic [CNT_W-1:0]             load_cnt
`ifdef WB_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH+CNT_W-1:0]  checksum
`endif
);

   logic [TAPS*DATA_WIDTH-1:0] shadow_q;
   logic [TAPS*DATA_WIDTH-1:0] weights_q;
   logic [CNT_W-1:0]           load_cnt_q;
   logic                       loaded_q;
   logic                       done_q;
   logic                       accept;
   logic                       commit;

   assign ready_out   = !loaded_q;
   assign accept      = valid_in && ready_out && !flush;
   assign commit      = start && loaded_q && !flush;
   assign loaded      = loaded_q;
   assign done        = done_q;
   assign weights_out = weights_q;
   assign load_cnt    = load_cnt_q;

   // Shadow storage needs no reset: a partial set is never committed.
   always_ff @(posedge clk) begin
      if (rst_n && accept) begin
         shadow_q[int'(load_cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_cnt_q <= '0;
         loaded_q   <= 1'b0;
         done_q     <= 1'b0;
         weights_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            load_cnt_q <= '0;
            loaded_q   <= 1'b0;
         end else if (commit) begin
            weights_q <= shadow_q;
            loaded_q  <= 1'b0;
            done_q    <= 1'b1;
         end else if (accept) begin
            if (load_cnt_q == CNT_W'(TAPS - 1)) begin
               load_cnt_q <= '0;
               loaded_q   <= 1'b1;
            end else begin
               load_cnt_q <= load_cnt_q + 1'b1;
            end
         end
      end
   end

`ifdef WB_CHECKSUM_EN
   logic [DATA_WIDTH+CNT_W-1:0] sum_q;
   logic [DATA_WIDTH+CNT_W-1:0] checksum_q;

   assign checksum = checksum_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q      <= '0;
         checksum_q <= '0;
      end else if (flush) begin
         sum_q <= '0;
      end else if (commit) begin
         checksum_q <= sum_q;
         sum_q      <= '0;
      end else if (accept) begin
         // Sign-extend so the sum is a true two's-complement total.
         sum_q <= sum_q + {{CNT_W{data_in[DATA_WIDTH-1]}}, data_in};
      end
   end
`endif

endmodule
